// File: rtl/nibble_packer.sv
// rtl/nibble_packer.sv - LSB-first nibble-to-word packer with assembly and output buffers.
// Optional partial-word flush is enabled by defining PACKER_FLUSH_EN.
module nibble_packer #(
    parameter  int NIBBLES = 8,
    parameter  int WIDTH   = 4,
    localparam int W       = NIBBLES * WIDTH,
    localparam int CW      = $clog2(NIBBLES + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [W-1:0]      out_data,
    output logic [CW-1:0]     out_count,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [CW-1:0] LAST_IDX = CW'(NIBBLES - 1);

    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_asm;
    logic          r_asm_full;
    logic [CW-1:0] r_held_cnt;
    logic [W-1:0]  r_out_data;
    logic [CW-1:0] r_out_count;
    logic          r_out_valid;

    logic          w_accept;
    logic [CW-1:0] w_cnt_eff;
    logic [W-1:0]  w_asm_next;
    logic          w_word_full;
    logic          w_flush_fire;
    logic          w_complete;
    logic          w_slot_free;

    assign w_accept    = in_valid && !r_asm_full;
    assign w_cnt_eff   = r_cnt + {{(CW-1){1'b0}}, w_accept};
    assign w_word_full = w_accept && (r_cnt == LAST_IDX);
    assign w_slot_free = !r_out_valid || out_ready;

`ifdef PACKER_FLUSH_EN
    // Flush counts a nibble accepted on the same edge; an empty or stalled assembly ignores it.
    assign w_flush_fire = flush && !r_asm_full && (w_cnt_eff != '0);
`else
    assign w_flush_fire = flush & 1'b0;
`endif

    assign w_complete = w_word_full || w_flush_fire;

    always_comb begin
        w_asm_next = r_asm;
        for (int k = 0; k < NIBBLES; k++) begin
            if (w_accept && (r_cnt == CW'(k))) begin
                w_asm_next[k*WIDTH +: WIDTH] = in_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_asm       <= '0;
            r_asm_full  <= 1'b0;
            r_held_cnt  <= '0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_valid <= 1'b0;
        end else if (clear) begin
            r_cnt       <= '0;
            r_asm       <= '0;
            r_asm_full  <= 1'b0;
            r_held_cnt  <= '0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_valid <= 1'b0;
        end else if (r_asm_full) begin
            // A held word implies out_valid is high, so moving it keeps out_valid asserted.
            if (w_slot_free) begin
                r_out_data  <= r_asm;
                r_out_count <= r_held_cnt;
                r_out_valid <= 1'b1;
                r_asm       <= '0;
                r_asm_full  <= 1'b0;
            end
        end else if (w_complete) begin
            r_cnt <= '0;
            if (w_slot_free) begin
                r_out_data  <= w_asm_next;
                r_out_count <= w_cnt_eff;
                r_out_valid <= 1'b1;
                r_asm       <= '0;
            end else begin
                r_asm      <= w_asm_next;
                r_held_cnt <= w_cnt_eff;
                r_asm_full <= 1'b1;
            end
        end else begin
            r_asm <= w_asm_next;
            r_cnt <= w_cnt_eff;
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = !r_asm_full;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_nibble_packer.sv
// tb/tb_nibble_packer.sv - Scoreboard bench for nibble_packer; flush cases follow PACKER_FLUSH_EN.
module tb_nibble_packer;

    logic        clock;
    logic        reset;
    logic        clear;
    logic [3:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] out_data;
    logic [3:0]  out_count;
    logic        out_valid;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;
    int stalls   = 0;

    logic [31:0] exp_data[$];
    logic [3:0]  exp_cnt[$];

    nibble_packer #(.NIBBLES(8), .WIDTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] c);
        exp_data.push_back(d);
        exp_cnt.push_back(c);
    endtask

    // Monitor: every completed output handshake is popped and compared.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_data.size() == 0) begin
                check("unexpected_word", out_data, 32'hxxxxxxxx);
            end else begin
                check("word_data", out_data, exp_data.pop_front());
                check("word_count", {28'd0, out_count}, {28'd0, exp_cnt.pop_front()});
            end
        end
    end

    task automatic send(input logic [3:0] v);
        bit done;
        done     = 0;
        in_data  = v;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clock);
            if (in_ready) begin
                @(posedge clock);
                #1;
                done = 1;
            end else begin
                stalls++;
            end
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; in_data = '0; in_valid = 1'b0;
        flush = 1'b0; out_ready = 1'b0;
        tick(2);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_count", {28'd0, out_count}, 32'd0);
        reset = 1'b0;
        tick(1);

        // Single word, one-cycle out_valid on the 8th accepting edge
        out_ready = 1'b1;
        expect_word(32'h87654321, 4'd8);
        for (int i = 1; i <= 7; i++) send(4'(i));
        check("pre_last_valid", {31'd0, out_valid}, 32'd0);
        send(4'd8);
        check("latency_valid", {31'd0, out_valid}, 32'd1);
        tick(1);
        check("one_cycle_valid", {31'd0, out_valid}, 32'd0);

        // 24-nibble back-to-back stream
        stalls = 0;
        expect_word(32'h76543210, 4'd8);
        expect_word(32'hFEDCBA98, 4'd8);
        expect_word(32'h76543210, 4'd8);
        for (int i = 0; i < 24; i++) send(4'(i % 16));
        check("stream_no_stall", stalls, 0);
        tick(2);

        // Output stalled: second word parks in the assembly register
        out_ready = 1'b0;
        stalls = 0;
        expect_word(32'h76543210, 4'd8);
        expect_word(32'hFEDCBA98, 4'd8);
        for (int i = 0; i < 16; i++) send(4'(i));
        check("stall_no_stall_input", stalls, 0);
        check("stall_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("stall_held_word", out_data, 32'h76543210);
        tick(2);
        check("stall_still_low", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick(1);
        check("drain_load_valid", {31'd0, out_valid}, 32'd1);
        check("drain_load_data", out_data, 32'hFEDCBA98);
        check("drain_in_ready", {31'd0, in_ready}, 32'd1);
        tick(2);
        check("drained_valid", {31'd0, out_valid}, 32'd0);

        // Clear discards a partial word
        for (int i = 1; i <= 5; i++) send(4'(i));
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        expect_word(32'hFEDCBA98, 4'd8);
        for (int i = 8; i <= 15; i++) send(4'(i));
        tick(2);

        // Asynchronous reset while both buffers hold words
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(4'(i));
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        check("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("async_rst_data", out_data, 32'd0);
        @(negedge clock);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        tick(3);
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);

`ifdef PACKER_FLUSH_EN
        expect_word(32'h00000765, 4'd3);
        send(4'd5); send(4'd6); send(4'd7);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("flush_valid", {31'd0, out_valid}, 32'd1);
        tick(1);
        expect_word(32'h00000765, 4'd3);
        send(4'd5); send(4'd6);
        flush = 1'b1;
        send(4'd7);
        flush = 1'b0;
        check("flush_same_edge_valid", {31'd0, out_valid}, 32'd1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("flush_empty_ignored", {31'd0, out_valid}, 32'd0);
`else
        expect_word(32'h43210765, 4'd8);
        send(4'd5); send(4'd6); send(4'd7);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("flush_ignored", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i <= 4; i++) send(4'(i));
        check("after_flush_full_valid", {31'd0, out_valid}, 32'd1);
`endif
        tick(3);
        check("scoreboard_empty", exp_data.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
